// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and defaults
// for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Full_Adder: one-bit combinational full adder
// used as the serial adder's bit slice.
module Full_Adder (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic Ca,
  output logic Sum
);

  assign Sum = A ^ B ^ C;
  assign Ca  = (A & B) | (C & (A ^ B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: LSB-first bit-serial adder
// driving a single Full_Adder slice.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_s_sh;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_s_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             w_ca;
  logic             w_sum;
  logic             w_last;

  Full_Adder u_fa (
    .A   (r_a_sh[0]),
    .B   (r_b_sh[0]),
    .C   (r_carry),
    .Ca  (w_ca),
    .Sum (w_sum)
  );

  // Only the upper WIDTH-1 partial-sum bits
  // survive; the new bit enters at the MSB.
  assign w_s_nxt = {w_sum, r_s_sh};
  assign w_last  = (r_cnt == LAST);

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: start only counts in IDLE.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: load, shift one bit per RUN
  // cycle, publish the result on the last.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_a_sh  <= a_in;
        r_b_sh  <= b_in;
        r_carry <= cin;
        r_cnt   <= '0;
      end
    end else if (r_state == RUN) begin
      r_carry <= w_ca;
      r_s_sh  <= w_s_nxt[WIDTH-1:1];
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      if (w_last) begin
        r_sum  <= w_s_nxt;
        r_cout <= w_ca;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign sum_out  = r_sum;
  assign cout_out = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed vector table,
// corner sequences and random ops at W=8/16.
module tb_serial_adder_ctrl;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, start16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        cin8, cin16;
  logic        busy8, done8, cout8;
  logic        busy16, done16, cout16;
  logic [7:0]  sum8;
  logic [15:0] sum16;

  int n_vec = 0;
  int n_err = 0;

  vec_t tv [7];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8),
    .a_in(a8), .b_in(b8), .cin(cin8),
    .busy(busy8), .done(done8),
    .sum_out(sum8), .cout_out(cout8)
  );

  serial_adder_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16),
    .a_in(a16), .b_in(b16), .cin(cin16),
    .busy(busy16), .done(done16),
    .sum_out(sum16), .cout_out(cout16)
  );

  task automatic chk(input string nm,
                     input logic [32:0] act,
                     input logic [32:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One W=8 op from IDLE; returns one edge
  // after done drops (earliest next start).
  task automatic op8(input logic [7:0] a,
                     input logic [7:0] b,
                     input logic c,
                     input logic [7:0] es,
                     input logic eco,
                     input string tag);
    int dn, de;
    logic bok;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    bok = busy8 & ~done8;
    dn = 0; de = -1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (!busy8) bok = 1'b0;
      if (done8) begin dn++; de = e; end
    end
    chk({tag, " busy"}, 33'(bok), 33'(1));
    chk({tag, " ndone"}, 33'(dn), 33'(1));
    chk({tag, " done_edge"}, 33'(de), 33'(8));
    chk({tag, " sum"}, 33'(sum8), 33'(es));
    chk({tag, " cout"}, 33'(cout8), 33'(eco));
    tick();
    chk({tag, " idle"}, 33'({busy8, done8}),
        33'(0));
  endtask

  task automatic op16(input logic [15:0] a,
                      input logic [15:0] b,
                      input logic c);
    logic [16:0] ex;
    int dn, de;
    ex = {1'b0, a} + {1'b0, b} + {16'd0, c};
    a16 = a; b16 = b; cin16 = c;
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    dn = 0; de = -1;
    for (int e = 1; e <= 17; e++) begin
      tick();
      if (done16) begin dn++; de = e; end
    end
    chk("w16 ndone", 33'(dn), 33'(1));
    chk("w16 done_edge", 33'(de), 33'(16));
    chk("w16 result", 33'({cout16, sum16}),
        33'(ex));
    chk("w16 idle", 33'(busy16), 33'(0));
  endtask

  initial begin
    int dn, d0, d1, bad;
    logic [7:0] ra, rb;
    logic rc;
    logic [8:0] rex;

    tv[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    tv[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tv[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tv[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    tv[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tv[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    tv[6] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};

    rst_n = 1'b0;
    start8 = 1'b0; start16 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0;
    a16 = '0; b16 = '0; cin16 = 1'b0;
    repeat (3) tick();
    chk("rst busy", 33'(busy8), 33'(0));
    chk("rst done", 33'(done8), 33'(0));
    chk("rst sum", 33'(sum8), 33'(0));
    chk("rst cout", 33'(cout8), 33'(0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++)
      op8(tv[i].a, tv[i].b, tv[i].c,
          tv[i].s, tv[i].co, $sformatf("tv%0d", i));

    // Held start: ops accepted at edges 0,10,20.
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
    start8 = 1'b1;
    dn = 0; d0 = -1; d1 = -1; bad = 0;
    for (int e = 0; e < 35; e++) begin
      if (e == 25) start8 = 1'b0;
      tick();
      if (done8) begin
        if (d0 < 0) d0 = e;
        d1 = e;
        dn++;
        if (sum8 !== 8'h03) bad++;
      end
    end
    chk("held ndone", 33'(dn), 33'(3));
    chk("held first", 33'(d0), 33'(8));
    chk("held span", 33'(d1 - d0), 33'(20));
    chk("held sum", 33'(bad), 33'(0));

    // Reset in the middle of an operation.
    a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid busy", 33'(busy8), 33'(0));
    chk("mid done", 33'(done8), 33'(0));
    chk("mid sum", 33'(sum8), 33'(0));
    chk("mid cout", 33'(cout8), 33'(0));
    dn = 0;
    for (int e = 0; e < 8; e++) begin
      tick();
      if (done8 | busy8) dn++;
    end
    chk("mid quiet", 33'(dn), 33'(0));
    op8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, "post");

    // Reset wins over start on the same edge.
    rst_n = 1'b0; start8 = 1'b1;
    a8 = 8'h11; b8 = 8'h22;
    tick();
    chk("rs busy", 33'(busy8), 33'(0));
    rst_n = 1'b1; start8 = 1'b0;
    tick();
    chk("rs busy2", 33'(busy8), 33'(0));
    chk("rs sum", 33'(sum8), 33'(0));

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rex = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      op8(ra, rb, rc, rex[7:0], rex[8], "rnd8");
    end

    op16(16'hFFFF, 16'h0001, 1'b0);
    op16(16'hFFFF, 16'hFFFF, 1'b1);
    for (int i = 0; i < 1000; i++)
      op16(16'($urandom), 16'($urandom),
           1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
